// File: rtl/exp_pkg.sv
// exp_pkg: constants shared by the exp(-a) evaluator, plus the elaboration-time
// generator for the exponent lookup tables.
//   Input  x : unsigned Q4.12 magnitude.
//   Output y : unsigned Q1.15 value of exp(-x/4096).
//   ROMs     : 18-bit unsigned Q1.17 factors.
package exp_pkg;

  localparam int EXP_INPUT_WIDTH_INT   = 4;
  localparam int EXP_INPUT_WIDTH_FRAC  = 12;
  localparam int EXP_OUTPUT_WIDTH_INT  = 1;
  localparam int EXP_OUTPUT_WIDTH_FRAC = 15;

  localparam int EXP_INPUT_WIDTH  = EXP_INPUT_WIDTH_INT + EXP_INPUT_WIDTH_FRAC;
  localparam int EXP_OUTPUT_WIDTH = EXP_OUTPUT_WIDTH_INT + EXP_OUTPUT_WIDTH_FRAC;

  localparam int ROM_W    = 18;
  localparam int ROM_FRAC = 17;

  // Largest legal result: exactly 1.0 in Q1.15.
  localparam logic [EXP_OUTPUT_WIDTH-1:0] Y_MAX = 16'h8000;

  // Working precision for the table generator. 60 fraction bits leaves a
  // very wide margin over the 17 bits that survive rounding.
  localparam int SERIES_FRAC = 60;

  // round_half_up(exp(-n * 2^-(12-4k)) * 2^17), evaluated with integers only
  // so the tables are constants at elaboration on any tool.
  // exp(-w) is summed as an alternating Taylor series (positive and negative
  // terms kept apart so every intermediate stays unsigned), then raised to
  // the n-th power by repeated multiplication.
  function automatic logic [ROM_W-1:0] rom_entry(input int k, input int n);
    logic [127:0] term;
    logic [127:0] sum_pos;
    logic [127:0] sum_neg;
    logic [127:0] base;
    logic [127:0] acc;
    int           shift;
    shift   = 12 - 4 * k;
    term    = 128'd1 << SERIES_FRAC;
    sum_pos = term;
    sum_neg = '0;
    for (int i = 1; i < 40; i++) begin
      term = (term >> shift) / 128'(i);
      if (i[0]) sum_neg = sum_neg + term;
      else      sum_pos = sum_pos + term;
    end
    base = sum_pos - sum_neg;
    acc  = 128'd1 << SERIES_FRAC;
    for (int j = 0; j < n; j++) begin
      acc = (acc * base) >> SERIES_FRAC;
    end
    acc = (acc + (128'd1 << (SERIES_FRAC - ROM_FRAC - 1))) >> (SERIES_FRAC - ROM_FRAC);
    return acc[ROM_W-1:0];
  endfunction

endpackage

// File: rtl/exp_if.sv
// exp_if: sample/result bundle of the exp(-a) evaluator.
//   data_valid : x is valid this cycle (master -> slave)
//   x          : Q4.12 magnitude      (master -> slave)
//   y          : Q1.15 result         (slave -> master)
//   new_result : y updated this cycle (slave -> master)
interface exp_if;
  import exp_pkg::*;

  logic                        data_valid;
  logic [EXP_INPUT_WIDTH-1:0]  x;
  logic [EXP_OUTPUT_WIDTH-1:0] y;
  logic                        new_result;

  modport master (output data_valid, output x, input y, input new_result);
  modport slave  (input data_valid, input x, output y, output new_result);

endinterface

// File: rtl/exp_rom.sv
// exp_rom: 16-entry x 18-bit lookup of exp(-n * 2^-(12-4*WEIGHT_K)) in Q1.17,
// registered read. WEIGHT_K = 3 is the integer nibble, 0 the lowest fraction
// nibble.
//   clk  : clock
//   addr : nibble value n
//   data : table entry, valid the cycle after addr
module exp_rom
  import exp_pkg::*;
#(
  parameter int WEIGHT_K = 0
) (
  input  logic             clk,
  input  logic [3:0]       addr,
  output logic [ROM_W-1:0] data
);

  logic [ROM_W-1:0] rom [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_entry
    localparam logic [ROM_W-1:0] ENTRY = rom_entry(WEIGHT_K, gi);
    assign rom[gi] = ENTRY;
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/exponential.sv
// exponential: pipelined y = exp(-a) evaluator, one sample per clock,
// result 6 edges after the sample edge.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low; clears valid bits, y and new_result
//   bus   : exp_if slave (data_valid, x in; y, new_result out)
// Stages: S1 capture, S2 ROM read, S3 R3*R2 / R1*R0, S4 truncate to A/B,
// S5 A*B, S6 truncate to P and round/saturate, S7 output register.
module exponential
  import exp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  exp_if.slave bus
);

  localparam int PROD_W = 2 * ROM_W;
  localparam int RND_W  = ROM_W + 1;

  logic [EXP_INPUT_WIDTH-1:0]  x_reg;
  logic [ROM_W-1:0]            rom_data [4];
  logic [PROD_W-1:0]           prod_hi_reg;
  logic [PROD_W-1:0]           prod_lo_reg;
  logic [ROM_W-1:0]            a_reg;
  logic [ROM_W-1:0]            b_reg;
  logic [PROD_W-1:0]           prod_ab_reg;
  logic [EXP_OUTPUT_WIDTH-1:0] res_reg;
  logic [5:0]                  valid_reg;   // [0] = S1 ... [5] = S6

  logic [ROM_W-1:0]            p_next;
  logic [RND_W-1:0]            rnd_next;
  logic [EXP_OUTPUT_WIDTH-1:0] res_next;

  // One table per nibble; nibble k carries weight 2^-(12-4k).
  for (genvar gi = 0; gi < 4; gi++) begin : g_rom
    exp_rom #(.WEIGHT_K(gi)) u_rom (
      .clk  (clk),
      .addr (x_reg[4*gi +: 4]),
      .data (rom_data[gi])
    );
  end

  // Valid bit travels beside the data; only it and the outputs are reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[4:0], bus.data_valid};
    end
  end

  // Data stages load unconditionally; idle cycles carry don't-care values.
  // Every factor is <= 1.0 in Q1.17, so products fit in 35 bits and the
  // truncated values fit back into 18 bits.
  always_ff @(posedge clk) begin
    x_reg       <= bus.x;
    prod_hi_reg <= PROD_W'(rom_data[3]) * PROD_W'(rom_data[2]);
    prod_lo_reg <= PROD_W'(rom_data[1]) * PROD_W'(rom_data[0]);
    a_reg       <= ROM_W'(prod_hi_reg >> ROM_FRAC);
    b_reg       <= ROM_W'(prod_lo_reg >> ROM_FRAC);
    prod_ab_reg <= PROD_W'(a_reg) * PROD_W'(b_reg);
    res_reg     <= res_next;
  end

  // Q1.17 -> Q1.15 with round-half-up; the clamp only matters if P = 1.0.
  always_comb begin
    p_next   = ROM_W'(prod_ab_reg >> ROM_FRAC);
    rnd_next = (RND_W'(p_next) + RND_W'(2)) >> 2;
    res_next = EXP_OUTPUT_WIDTH'(rnd_next);
    if (rnd_next > RND_W'(Y_MAX)) begin
      res_next = Y_MAX;
    end
  end

  // y holds across idle cycles; new_result marks each fresh value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.y          <= '0;
      bus.new_result <= 1'b0;
    end else begin
      bus.new_result <= valid_reg[5];
      if (valid_reg[5]) begin
        bus.y <= res_reg;
      end
    end
  end

endmodule

// File: tb/tb_exponential.sv
// tb_exponential: scoreboard bench for the exp(-a) evaluator. Expected results
// (from a real-valued reference model or fixed known values) are queued with
// their due edge when a sample is driven, and popped when new_result appears.
module tb_exponential;
  import exp_pkg::*;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          due;
  } sb_t;

  logic clk;
  logic reset;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [15:0] last_y = '0;
  sb_t  sb_q[$];

  exp_if bus ();

  exponential dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  // Reference table entry: round_half_up(exp(-n * 16^-(3-k)) * 2^17).
  function automatic longint unsigned rom_m(input int k, input int n);
    real w;
    w = 1.0;
    for (int i = 0; i < 3 - k; i++) w = w / 16.0;
    return longint'($rtoi($floor($exp(-real'(n) * w) * 131072.0 + 0.5)));
  endfunction

  function automatic logic [15:0] model(input logic [15:0] xv);
    longint unsigned r3, r2, r1, r0, a, b, p, yv;
    r3 = rom_m(3, int'(xv[15:12]));
    r2 = rom_m(2, int'(xv[11:8]));
    r1 = rom_m(1, int'(xv[7:4]));
    r0 = rom_m(0, int'(xv[3:0]));
    a  = (r3 * r2) >> 17;
    b  = (r1 * r0) >> 17;
    p  = (a * b) >> 17;
    yv = (p + 2) >> 2;
    if (yv > 32768) yv = 32768;
    return 16'(yv);
  endfunction

  // Present one sample for the next rising edge; its result is due 6 edges
  // after that sampling edge.
  task automatic drive_exp(input logic v, input logic [15:0] xv, input logic [15:0] ye);
    sb_t e;
    bus.data_valid = v;
    bus.x          = xv;
    if (v) begin
      e.x   = xv;
      e.y   = ye;
      e.due = edge_cnt + 7;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] xv);
    drive_exp(v, xv, model(xv));
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (reset) begin
      if (bus.new_result) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("y", bus.y, e.y);
          check_eq("latency", edge_cnt, e.due);
          last_y = e.y;
          $display("result x=0x%04h y=0x%04h expected=0x%04h edge=%0d", e.x, bus.y, e.y, edge_cnt);
        end
      end else begin
        check_eq("hold_y", bus.y, last_y);
        if (sb_q.size() > 0 && edge_cnt >= sb_q[0].due) begin
          e = sb_q.pop_front();
          check_eq("missing_result", 0, 1);
        end
      end
    end
  end

  initial begin
    reset          = 1'b0;
    bus.data_valid = 1'b1;
    bus.x          = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_y", bus.y, 0);
    check_eq("reset_new_result", bus.new_result, 0);

    // Release with x = 0 held valid: 0x8000 from the 6th edge on.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) drive_exp(1'b1, 16'h0000, 16'h8000);

    // Known points: a = 1.0 and the largest magnitude.
    drive_exp(1'b1, 16'h1000, 16'h2F17);
    drive_exp(1'b1, 16'hFFFF, 16'h0000);
    drive(1'b1, 16'h0001);
    drive(1'b1, 16'h0FFF);
    drive(1'b1, 16'h8000);

    // Back-to-back pseudo-random stream.
    for (int i = 0; i < 1000; i++) drive(1'b1, 16'($urandom_range(0, 65535)));

    // Valid pattern 1,0,0,1 with don't-care data on idle cycles.
    drive(1'b1, 16'h0100);
    drive(1'b0, 16'h1234);
    drive(1'b0, 16'h4321);
    drive(1'b1, 16'h0200);
    for (int i = 0; i < 10; i++) drive(1'b0, 16'($urandom_range(0, 65535)));
    check_eq("drain", sb_q.size(), 0);

    // Reset with three samples in flight: outputs clear at once and the
    // samples never emerge.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0300);
    bus.data_valid = 1'b0;
    #1;
    reset = 1'b0;
    sb_q.delete();
    last_y = '0;
    #1;
    check_eq("async_reset_y", bus.y, 0);
    check_eq("async_reset_new_result", bus.new_result, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) drive(1'b0, 16'h0000);
    check_eq("flushed", sb_q.size(), 0);

    // First sample after the second release.
    drive(1'b1, 16'h0800);
    for (int i = 0; i < 8; i++) drive(1'b0, 16'h0000);
    check_eq("final_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
